// File: rtl/spi_defs.sv
// Shared definitions for the SPI serial-clock engine and related timing blocks.
// Holds FSM state encodings, default widths and SPI mode encodings.
// No logic; constants only.
package spi_defs;

    localparam int DEF_DIV_W = 16;
    localparam int DEF_LEN_W = 7;

    // Engine FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TAIL = 2'd2;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_half_period_cnt.sv
// Loadable down-counter with zero flag; reloads itself when enabled at zero.
// Latency: load/decrement visible the cycle after; zero flag is combinational.
// No backpressure: counts whenever enabled.
module spi_half_period_cnt #(
    parameter int W = 16
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic [W-1:0] i_reload_val,
    output logic         o_zero
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_cnt;

    // Explicit load wins; otherwise count down and wrap to the reload value at zero
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt <= '1;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= i_reload_val;
            end else begin
                r_cnt <= r_cnt - ONE;
            end
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI master SCLK generator: all four modes, programmable divider and bit count.
// Latency: edge k registers k*(divider+1) cycles after start; done after one extra half-period.
// No backpressure: start is dropped unless idle; abort returns to idle next cycle.
module spi_sclk_engine
    import spi_defs::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [DIV_W-1:0] i_divider,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_cpol,
    input  logic             i_cpha,
    output logic             o_sclk,
    output logic             o_sample_stb,
    output logic             o_shift_stb,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_bit_cnt
);

    localparam logic [LEN_W+1:0] EDGE_ONE = {{(LEN_W+1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] BIT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_div;
    logic [LEN_W-1:0] r_len;
    logic             r_cpol;
    logic             r_cpha;
    logic [LEN_W+1:0] r_edge_cnt;
    logic             r_sclk;
    logic             r_sample_stb;
    logic             r_shift_stb;
    logic             r_busy;
    logic             r_done;
    logic [LEN_W-1:0] r_bit_cnt;

    logic             w_load;
    logic             w_cnt_en;
    logic             w_zero;
    logic [LEN_W:0]   w_nbits;
    logic [LEN_W+1:0] w_two_n;
    logic [LEN_W+1:0] w_k;
    logic             w_leading;
    logic             w_last;
    logic             w_samp_edge;
    logic             w_shift_edge;

    assign w_load   = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_cnt_en = (r_state != ST_IDLE) && !i_abort;

    spi_half_period_cnt #(
        .W (DIV_W)
    ) u_half_cnt (
        .clk_in       (clk_in),
        .rst          (rst),
        .i_load       (w_load),
        .i_load_val   (i_divider),
        .i_en         (w_cnt_en),
        .i_reload_val (r_div),
        .o_zero       (w_zero)
    );

    // len==0 means 2^LEN_W bits, which is exactly the extra MSB set with zero low bits
    assign w_nbits      = {(r_len == '0), r_len};
    assign w_two_n      = {w_nbits, 1'b0};
    assign w_k          = r_edge_cnt + EDGE_ONE;
    assign w_leading    = w_k[0];
    assign w_last       = (w_k == w_two_n);
    assign w_samp_edge  = r_cpha ? ~w_leading : w_leading;
    // In cpha=0 the first bit is already on MOSI, so the final trailing edge has nothing to shift
    assign w_shift_edge = r_cpha ? w_leading : (~w_leading & ~w_last);

    // Transfer FSM: latches configuration, toggles SCLK on half-period expiry, emits strobes
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_div        <= '0;
            r_len        <= '0;
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_edge_cnt   <= '0;
            r_sclk       <= 1'b0;
            r_sample_stb <= 1'b0;
            r_shift_stb  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bit_cnt    <= '0;
        end else begin
            r_sample_stb <= 1'b0;
            r_shift_stb  <= 1'b0;
            r_done       <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_sclk  <= r_cpol;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_sclk <= i_cpol;
                        if (i_start) begin
                            r_div      <= i_divider;
                            r_len      <= i_len;
                            r_cpol     <= i_cpol;
                            r_cpha     <= i_cpha;
                            r_edge_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_zero) begin
                            r_sclk       <= ~r_sclk;
                            r_edge_cnt   <= w_k;
                            r_sample_stb <= w_samp_edge;
                            r_shift_stb  <= w_shift_edge;
                            if (w_samp_edge) begin
                                r_bit_cnt <= r_bit_cnt + BIT_ONE;
                            end
                            if (w_last) begin
                                r_state <= ST_TAIL;
                            end
                        end
                    end
                    ST_TAIL: begin
                        if (w_zero) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sclk       = r_sclk;
    assign o_sample_stb = r_sample_stb;
    assign o_shift_stb  = r_shift_stb;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_bit_cnt    = r_bit_cnt;

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised next-generation SPI serial-clock engine for the SPI master.
- Generates SCLK for all four SPI modes (CPOL/CPHA) with a programmable divider.
- Counts a programmable number of bits per transfer; emits single-cycle sample/shift strobes for the shift register.
- Provides a start/busy/done handshake with abort, so the master core no longer tracks last-clock itself.

Parameters:
- DIV_W, 16: divider width; SCLK half-period = divider+1 clk_in cycles.
- LEN_W, 7: bit-length width; len=0 encodes 2^LEN_W bits.

Ports:
- clk_in  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; honoured only in IDLE
- abort  in  1  terminate transfer; returns engine to IDLE
- divider  in  DIV_W  half-period minus one
- len  in  LEN_W  bits per transfer (0 = 2^LEN_W)
- cpol  in  1  SCLK idle level
- cpha  in  1  0: sample on leading edge, 1: sample on trailing edge
- sclk  out  1  serial clock
- sample_stb  out  1  pulse; capture MISO this cycle
- shift_stb  out  1  pulse; advance MOSI this cycle
- busy  out  1  transfer in progress (RUN or TAIL)
- done  out  1  one-cycle pulse at normal completion
- bit_cnt  out  LEN_W  sample strobes issued in current transfer

Behaviour:
- Reset values: sclk=0, sample_stb=0, shift_stb=0, busy=0, done=0, bit_cnt=0, state=IDLE, half-counter=all ones, latched cpol=0.
- All outputs are registered.
- States: IDLE, RUN, TAIL.
- IDLE:
  - sclk = current cpol input, tracked each cycle.
  - When start=1 and abort=0: latch divider, len, cpol, cpha; load half-counter with divider; clear edge counter and bit_cnt; go to RUN. busy=1 from the next cycle.
- RUN:
  - Half-counter decrements each cycle.
  - When it equals 0: reload it with the latched divider, toggle sclk, increment the edge counter, and assert the edge strobe in the same cycle sclk changes.
  - Edge k (1..2N, N = latched len, 0 → 2^LEN_W): odd k = leading edge (away from cpol), even k = trailing edge.
  - cpha=0: sample_stb on leading edges; shift_stb on trailing edges except edge 2N (N-1 shifts). The first bit is presented by the shifter at start.
  - cpha=1: shift_stb on leading edges (N shifts); sample_stb on trailing edges.
  - bit_cnt increments with each sample_stb and saturates at N (stored as 0 when N=2^LEN_W, wraps naturally).
  - After edge 2N, sclk is back at cpol; go to TAIL with half-counter reloaded.
- TAIL:
  - Waits one further half-period (divider+1 cycles) for slave hold time.
  - Then: done=1 for one cycle, busy=0 in that same cycle, state=IDLE.
- Timing: edge k registers at clk_in edge T0+k*(divider+1), where T0 is the edge that sampled start. done is high in the cycle after edge T0+(2N+1)*(divider+1).
- divider=0: sclk toggles every clk_in cycle; strobes may be high on consecutive cycles.
- Input changes to divider/len/cpol/cpha while busy are ignored; latched values are used.
- start while busy is ignored; no queueing.
- abort (any state): next cycle state=IDLE, sclk=latched cpol, strobes=0, busy=0, done=0, bit_cnt held. Abort has priority over start and over an edge in the same cycle.
- Asynchronous reset mid-transfer: immediate return to reset values; no done pulse.

Decomposition:
- Shared package spi_defs: state encoding (IDLE/RUN/TAIL); default DIV_W/LEN_W constants; mode encodings MODE0..MODE3 as {cpol,cpha}.
- Natural sub-module: spi_half_period_cnt (loadable down-counter with zero flag and reload), reusable by future slave-side timing logic.

Test Plan:
- Mode 0, divider=1, len=8, cpol=0, cpha=0:
  - First sclk rise 2 cycles after start; 16 edges, period 4.
  - 8 sample_stb on rises; 7 shift_stb on falls.
  - done 34 cycles after start; bit_cnt=8.
- Mode 3, divider=2, len=4, cpol=1, cpha=1:
  - sclk idles 1; first fall 3 cycles after start.
  - 4 shift_stb on falls; 4 sample_stb on rises.
  - sclk=1 at end; done at cycle 27.
- divider=0, len=0 (128 bits), mode 1:
  - sclk toggles every cycle; 256 edges; 128 sample_stb.
  - bit_cnt wraps to 0; done 257 cycles after start.
- Abort at cycle 10 of a divider=1, len=8, mode 2 transfer:
  - Next cycle sclk=1, busy=0, no done, bit_cnt holds its current value.
  - New start then runs a full transfer.
- start pulsed again mid-transfer, plus divider/cpol changed mid-transfer: ignored; timing and polarity of the original transfer unchanged.
- Asynchronous rst asserted mid-RUN, between clk_in edges: outputs go to reset values immediately; no done pulse.
